// File: rtl/leg_calc_pkg.sv
// Shared state encoding and default width for the leg_calc right-triangle leg calculator.
package leg_calc_pkg;

  localparam int LEG_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    SUB,
    ROOT
  } state_e;

endpackage

// File: rtl/leg_calc_isqrt_seq.sv
// Sequential restoring square root, one result bit per cycle MSB first.
// With LEG_CALC_ROUND_EN defined, the result is rounded to nearest instead of floored.
module isqrt_seq
  import leg_calc_pkg::*;
#(
  parameter int W = LEG_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] radicand,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] rad_q,  rad_d;
  logic [2*W:0]   rem_q,  rem_d;
  logic [W-1:0]   root_q, root_d;
  logic [CW-1:0]  cnt_q,  cnt_d;
  logic           busy_q, busy_d;
  logic [2*W+2:0] rem_sh;
  logic [2*W+2:0] trial;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done   = 1'b0;
    // Bring down the next two radicand bits and try subtracting 4*root+1.
    rem_sh = {rem_q, rad_q[2*W-1 -: 2]};
    trial  = {{(W + 1){1'b0}}, root_q, 2'b01};

    if (start) begin
      rad_d  = radicand;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rad_d = rad_q << 2;
      if (rem_sh >= trial) begin
        rem_d  = (2*W+1)'(rem_sh - trial);
        root_d = {root_q[W-2:0], 1'b1};
      end else begin
        rem_d  = rem_sh[2*W:0];
        root_d = {root_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  // The result reflects this cycle's step so the caller can load it on the final edge.
`ifdef LEG_CALC_ROUND_EN
  always_comb begin
    result = root_d;
    if (rem_d > {{(W + 1){1'b0}}, root_d}) result = root_d + 1'b1;
  end
`else
  assign result = root_d;
`endif

  assign busy = busy_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/leg_calc.sv
// Computes the missing leg y = sqrt(c*c - a*a) of a right triangle: shift-add squaring,
// subtract, then sequential square root. LEG_CALC_ROUND_EN selects round-to-nearest.
module leg_calc
  import leg_calc_pkg::*;
#(
  parameter int W = LEG_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] c,
  input  logic [W-1:0] a,
  output logic         ready,
  output logic         busy,
  output logic         err,
  output logic [W-1:0] y
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);

  state_e          state_q, state_d;
  logic [W-1:0]    c_q,  c_d;
  logic [W-1:0]    a_q,  a_d;
  logic [W-1:0]    mc_q, mc_d;
  logic [W-1:0]    ma_q, ma_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [PW-1:0]   pa_q, pa_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [W-1:0]    y_q,  y_d;

  logic [PW-1:0]   diff;
  logic            sq_start;
  logic            sq_busy;
  logic            sq_done;
  logic [W-1:0]    sq_result;

  assign diff = pc_q - pa_q;

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    a_d      = a_q;
    mc_d     = mc_q;
    ma_d     = ma_q;
    pc_d     = pc_q;
    pa_d     = pa_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    y_d      = y_q;
    sq_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          c_d     = c;
          a_d     = a;
          mc_d    = c;
          ma_d    = a;
          pc_d    = '0;
          pa_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        // Both squares share the bit index: add the shifted operand when its bit is set.
        if (mc_q[0]) pc_d = pc_q + (PW'(c_q) << cnt_q);
        if (ma_q[0]) pa_d = pa_q + (PW'(a_q) << cnt_q);
        mc_d  = mc_q >> 1;
        ma_d  = ma_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = SUB;
      end
      SUB: begin
        if (a_q > c_q) begin
          err_d   = 1'b1;
          y_d     = '0;
          state_d = IDLE;
        end else begin
          sq_start = 1'b1;
          state_d  = ROOT;
        end
      end
      ROOT: begin
        if (sq_done) begin
          y_d     = sq_result;
          state_d = IDLE;
        end else if (!sq_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  isqrt_seq #(
    .W(W)
  ) u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start   (sq_start),
    .radicand(diff),
    .busy    (sq_busy),
    .done    (sq_done),
    .result  (sq_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      a_q     <= '0;
      mc_q    <= '0;
      ma_q    <= '0;
      pc_q    <= '0;
      pa_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      a_q     <= a_d;
      mc_q    <= mc_d;
      ma_q    <= ma_d;
      pc_q    <= pc_d;
      pa_q    <= pa_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      y_q     <= y_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;
  assign err   = err_q;
  assign y     = y_q;

endmodule

// File: tb/tb_leg_calc.sv
// Self-checking bench for leg_calc: directed corner cases plus randomized operations
// scored against an arithmetic reference model of the missing-leg computation.
module tb_leg_calc;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] c;
  logic [W-1:0] a;
  logic         ready;
  logic         busy;
  logic         err;
  logic [W-1:0] y;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int y_exp    = 0;

  leg_calc #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .c    (c),
    .a    (a),
    .ready(ready),
    .busy (busy),
    .err  (err),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: largest r with r*r <= c*c - a*a, optionally rounded to nearest.
  function automatic int ref_leg(input int ci, input int ai);
    int d;
    int r;
    d = ci * ci - ai * ai;
    r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
`ifdef LEG_CALC_ROUND_EN
    if (d - r * r > r) r++;
`endif
    return r;
  endfunction

  // Issue one operation, optionally pulsing start again while busy, then score it.
  task automatic run_op(input int ci, input int ai, input int poke_at);
    int  cycles;
    bit  exp_err;
    int  exp_y;
    int  exp_busy;
    exp_err  = (ai > ci);
    exp_y    = exp_err ? 0 : ref_leg(ci, ai);
    exp_busy = exp_err ? W + 1 : 2 * W + 1;

    @(negedge clk);
    start = 1'b1;
    c = W'(ci);
    a = W'(ai);
    @(negedge clk);
    c = W'($urandom);
    a = W'($urandom);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (cycles == 1) begin
        check("y_hold_on_accept", 32'(y), 32'(y_exp));
        check("err_clear_on_accept", 32'(err), 0);
      end
      start = (cycles == poke_at);
      if (cycles == poke_at) begin
        c = 9;
        a = 4;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("busy_len c=%0d a=%0d", ci, ai), 32'(cycles), 32'(exp_busy));
    check($sformatf("y c=%0d a=%0d", ci, ai), 32'(y), 32'(exp_y));
    check($sformatf("err c=%0d a=%0d", ci, ai), 32'(err), 32'(exp_err));
    check("ready_after_op", 32'(ready), 1);
    y_exp = exp_y;
  endtask

  initial begin
    int cycles;
    int ci;
    int ai;
    rst   = 1'b0;
    start = 1'b0;
    c     = '0;
    a     = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_err", 32'(err), 0);
    check("reset_y", 32'(y), 0);
    rst = 1'b1;

    // Directed corner cases.
    run_op(5, 3, 0);
    run_op(3, 5, 0);
    run_op(13, 5, 0);
    run_op(255, 0, 0);
    run_op(200, 200, 0);
    run_op(3, 1, 0);
    run_op(255, 254, 0);

    // Start pulsed mid-operation must not disturb the operands in flight.
    run_op(5, 3, 3);

    // Start held high: the next operation begins on the first IDLE cycle.
    @(negedge clk);
    start = 1'b1;
    c = 5;
    a = 3;
    @(negedge clk);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    check("b2b_first_busy_len", 32'(cycles), 32'(2 * W + 1));
    check("b2b_first_y", 32'(y), 32'(ref_leg(5, 3)));
    check("b2b_idle_ready", 32'(ready), 1);
    c = 13;
    a = 5;
    @(negedge clk);
    check("b2b_restart_busy", 32'(busy), 1);
    start = 1'b0;
    cycles = 1;
    while (busy === 1'b1 && cycles < 200) begin
      @(negedge clk);
      if (busy === 1'b1) cycles++;
    end
    check("b2b_second_busy_len", 32'(cycles), 32'(2 * W + 1));
    check("b2b_second_y", 32'(y), 32'(ref_leg(13, 5)));
    y_exp = ref_leg(13, 5);

    // Reset mid-operation abandons it; y stays cleared afterward.
    @(negedge clk);
    start = 1'b1;
    c = 5;
    a = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_y", 32'(y), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_ready", 32'(ready), 1);
    check("midreset_err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("postreset_y_unchanged", 32'(y), 0);
    check("postreset_idle", 32'(ready), 1);
    y_exp = 0;
    run_op(5, 3, 0);

    // Randomized operations, biased toward valid triangles with some error cases.
    for (int i = 0; i < 40; i++) begin
      ci = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) ai = int'($urandom_range(0, 255));
      else ai = int'($urandom_range(0, ci));
      run_op(ci, ai, (i % 5 == 0) ? int'($urandom_range(1, 2 * W)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/leg_calc.md
LEG_CALC -- requirements
Module: leg_calc

Interface
REQ-001 SHALL have parameter W, default 8: operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only while in IDLE.
REQ-005 SHALL have port c  input  W  hypotenuse, unsigned.
REQ-006 SHALL have port a  input  W  known leg, unsigned.
REQ-007 SHALL have port ready  output  1  high only in IDLE.
REQ-008 SHALL have port busy  output  1  logical inverse of ready.
REQ-009 SHALL have port err  output  1  set when a > c for the last accepted operation.
REQ-010 SHALL have port y  output  W  result floor(sqrt(c*c - a*a)), registered.

Function
REQ-011 SHALL use states IDLE, SQUARE, SUB, ROOT; only IDLE has busy=0.
REQ-012 IDLE: start=1 at an edge latches c and a, clears err, and enters SQUARE; y holds its previous value.
REQ-013 SHALL ignore start, c and a outside IDLE; they have no effect on operands in flight.
REQ-014 SQUARE: shift-add forms c*c and a*a in parallel, one multiplier bit per cycle, exactly W cycles, 2W-bit products.
REQ-015 SUB: one cycle; diff = c*c - a*a in 2W bits; if a > c, err<=1, y<=0, return to IDLE.
REQ-016 ROOT: restoring digit-by-digit square root of diff, one result bit per cycle MSB first, exactly W cycles; remainder kept to 2W+1 bits.
REQ-017 On ROOT exit, y SHALL load the root and the FSM SHALL return to IDLE in the same edge.
REQ-018 busy SHALL be high exactly 2W+1 cycles on the normal path and W+1 cycles on the error path (17/9 for W=8).
REQ-019 start held high continuously SHALL start a new operation on the first IDLE cycle after completion; back-to-back issue gap is zero cycles.
REQ-020 c == a SHALL give y=0, err=0; a=0 SHALL give y=c exactly.

Reset
REQ-021 rst low SHALL asynchronously force state=IDLE, ready=1, busy=0, err=0, y=0, and clear all datapath registers.
REQ-022 Reset asserted mid-operation SHALL abandon the operation without updating y afterward; the first start after release SHALL run normally.

Configuration
REQ-023 With LEG_CALC_ROUND_EN defined, y SHALL round to nearest: root+1 when the final remainder > root, otherwise root.
REQ-024 Without LEG_CALC_ROUND_EN, y SHALL be the floor root and the rounding logic SHALL be absent.
REQ-025 Latency SHALL be identical with and without the macro, and the rounded result SHALL never exceed c.

Structure
REQ-026 Package leg_calc_pkg SHALL hold the state enum typedef and the default width constant.
REQ-027 The square root datapath SHALL be a sub-module isqrt_seq with a start/busy handshake; the squarers stay in leg_calc.

Verification
REQ-028 c=5, a=3, start one cycle -> busy high 17 cycles, then y=4, err=0.
REQ-029 c=3, a=5 -> busy high 9 cycles, then err=1, y=0; next c=13, a=5 -> err=0, y=12.
REQ-030 c=255, a=0 -> y=255; c=200, a=200 -> y=0, err=0.
REQ-031 c=3, a=1 (diff 8) -> y=2 without LEG_CALC_ROUND_EN, y=3 with it.
REQ-032 Pulse start with c=9, a=4 mid-operation of c=5, a=3 -> ignored, y=4; rst low at cycle 6 -> immediate y=0, busy=0, no later y update.
